// File: rtl/control_unit_fsm.sv
// control_unit_fsm
//   Instruction sequencer for the 8-bit accumulator processor. Each instruction
//   runs FETCH -> DECODE -> one execute state. INPUT waits for Enter, and HALT
//   parks the machine until clear. It also keeps a saturating count of
//   completed instructions.
//
// Ports
//   clk          in   system clock, rising edge
//   clear        in   synchronous active-high reset
//   IR75         in   opcode, IR[7:5]
//   Aeq0, Apos   in   accumulator status (zero, signed positive)
//   Enter        in   operand-entry strobe for INPUT
//   IRload       out  load IR from instruction memory
//   PCload       out  load PC from IMP mux
//   IMPsel       out  1: PC <= IR[4:0], 0: PC <= PC+1
//   MeminstSel   out  1: memory address = IR[4:0], 0: = PC
//   Asel         out  A source: 00 adder, 01 external input, 10 memory
//   Aload        out  load accumulator
//   Sub          out  1: A - M, 0: A + M
//   MemWr        out  write A to memory
//   InReady      out  waiting for Enter
//   Halt         out  in HALT state
//   state        out  current state encoding
//   instr_count  out  completed-instruction count (saturating)
module control_unit_fsm #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [2:0]       IR75,
    input  logic             Aeq0,
    input  logic             Apos,
    input  logic             Enter,
    output logic             IRload,
    output logic             PCload,
    output logic             IMPsel,
    output logic             MeminstSel,
    output logic [1:0]       Asel,
    output logic             Aload,
    output logic             Sub,
    output logic             MemWr,
    output logic             InReady,
    output logic             Halt,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_INPUT  = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             count_inc;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= S_START;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            // Saturate rather than wrap.
            if (count_inc && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = S_START;
        count_inc  = 1'b0;
        IRload     = 1'b0;
        PCload     = 1'b0;
        IMPsel     = 1'b0;
        MeminstSel = 1'b0;
        Asel       = 2'b00;
        Aload      = 1'b0;
        Sub        = 1'b0;
        MemWr      = 1'b0;
        InReady    = 1'b0;
        Halt       = 1'b0;

        case (state_q)
            S_START: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                IRload  = 1'b1;
                PCload  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                MeminstSel = 1'b1;
                case (IR75)
                    3'b000:  state_d = S_LOAD;
                    3'b001:  state_d = S_STORE;
                    3'b010:  state_d = S_ADD;
                    3'b011:  state_d = S_SUB;
                    3'b100:  state_d = S_INPUT;
                    3'b101:  state_d = S_JZ;
                    3'b110:  state_d = S_JPOS;
                    default: state_d = S_HALT;
                endcase
                // HALT has no execute-to-FETCH transition, so it counts here.
                count_inc = (IR75 == 3'b111);
            end
            S_LOAD: begin
                MeminstSel = 1'b1;
                Asel       = 2'b10;
                Aload      = 1'b1;
                state_d    = S_FETCH;
                count_inc  = 1'b1;
            end
            S_STORE: begin
                MeminstSel = 1'b1;
                MemWr      = 1'b1;
                state_d    = S_FETCH;
                count_inc  = 1'b1;
            end
            S_ADD: begin
                MeminstSel = 1'b1;
                Aload      = 1'b1;
                state_d    = S_FETCH;
                count_inc  = 1'b1;
            end
            S_SUB: begin
                MeminstSel = 1'b1;
                Sub        = 1'b1;
                Aload      = 1'b1;
                state_d    = S_FETCH;
                count_inc  = 1'b1;
            end
            S_INPUT: begin
                InReady   = 1'b1;
                Asel      = 2'b01;
                Aload     = Enter;
                state_d   = Enter ? S_FETCH : S_INPUT;
                count_inc = Enter;
            end
            S_JZ: begin
                IMPsel    = 1'b1;
                PCload    = Aeq0;
                state_d   = S_FETCH;
                count_inc = 1'b1;
            end
            S_JPOS: begin
                IMPsel    = 1'b1;
                PCload    = Apos;
                state_d   = S_FETCH;
                count_inc = 1'b1;
            end
            S_HALT: begin
                Halt    = 1'b1;
                state_d = S_HALT;
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
module tb_control_unit_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default counter width; DUT B: 2-bit counter for saturation.
    logic       clear_a, aeq0_a, apos_a, enter_a;
    logic [2:0] ir_a;
    logic       irl_a, pcl_a, imp_a, mis_a, al_a, sub_a, mw_a, inr_a, hlt_a;
    logic [1:0] asel_a;
    logic [3:0] st_a;
    logic [15:0] cnt_a;

    logic       clear_b, aeq0_b, apos_b, enter_b;
    logic [2:0] ir_b;
    logic       irl_b, pcl_b, imp_b, mis_b, al_b, sub_b, mw_b, inr_b, hlt_b;
    logic [1:0] asel_b;
    logic [3:0] st_b;
    logic [1:0] cnt_b;

    control_unit_fsm #(.CNT_W(16)) dut_a (
        .clk(clk), .clear(clear_a), .IR75(ir_a), .Aeq0(aeq0_a), .Apos(apos_a),
        .Enter(enter_a), .IRload(irl_a), .PCload(pcl_a), .IMPsel(imp_a),
        .MeminstSel(mis_a), .Asel(asel_a), .Aload(al_a), .Sub(sub_a),
        .MemWr(mw_a), .InReady(inr_a), .Halt(hlt_a), .state(st_a),
        .instr_count(cnt_a)
    );

    control_unit_fsm #(.CNT_W(2)) dut_b (
        .clk(clk), .clear(clear_b), .IR75(ir_b), .Aeq0(aeq0_b), .Apos(apos_b),
        .Enter(enter_b), .IRload(irl_b), .PCload(pcl_b), .IMPsel(imp_b),
        .MeminstSel(mis_b), .Asel(asel_b), .Aload(al_b), .Sub(sub_b),
        .MemWr(mw_b), .InReady(inr_b), .Halt(hlt_b), .state(st_b),
        .instr_count(cnt_b)
    );

    // Packed as {state[3:0], IRload, PCload, IMPsel, MeminstSel, Asel[1:0],
    //            Aload, Sub, MemWr, InReady, Halt, count[15:0]}
    typedef struct {
        int          dut;
        logic [30:0] exp;
        string       tag;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    // Control outputs the spec lists for each state.
    function automatic logic [10:0] ctrl_of(input logic [3:0] st, input bit aeq0,
                                            input bit apos, input bit enter);
        logic irl, pcl, imp, mis, al, sb_, mw, inr, hl;
        logic [1:0] as;
        irl = 0; pcl = 0; imp = 0; mis = 0; al = 0; sb_ = 0; mw = 0; inr = 0; hl = 0;
        as = 2'b00;
        case (st)
            4'd1:  begin irl = 1; pcl = 1; end
            4'd2:  mis = 1;
            4'd8:  begin mis = 1; as = 2'b10; al = 1; end
            4'd9:  begin mis = 1; mw = 1; end
            4'd10: begin mis = 1; al = 1; end
            4'd11: begin mis = 1; al = 1; sb_ = 1; end
            4'd12: begin inr = 1; as = 2'b01; al = enter; end
            4'd13: begin imp = 1; pcl = aeq0; end
            4'd14: begin imp = 1; pcl = apos; end
            4'd15: hl = 1;
            default: ;
        endcase
        return {irl, pcl, imp, mis, as, al, sb_, mw, inr, hl};
    endfunction

    // One clock of stimulus: drive inputs for this cycle and push the outputs
    // expected for this cycle (state already reached at this edge).
    task automatic cyc(input int dut, input bit clr, input logic [2:0] ir,
                       input bit aeq0, input bit apos, input bit enter,
                       input logic [3:0] est, input int ecnt, input string tag);
        item_t it;
        @(posedge clk);
        #1;
        if (dut == 0) begin
            clear_a = clr; ir_a = ir; aeq0_a = aeq0; apos_a = apos; enter_a = enter;
        end else begin
            clear_b = clr; ir_b = ir; aeq0_b = aeq0; apos_b = apos; enter_b = enter;
        end
        it.dut = dut;
        it.exp = {est, ctrl_of(est, aeq0, apos, enter), 16'(ecnt)};
        it.tag = tag;
        sb.push_back(it);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            item_t it;
            logic [30:0] act;
            it = sb.pop_front();
            if (it.dut == 0)
                act = {st_a, irl_a, pcl_a, imp_a, mis_a, asel_a, al_a, sub_a, mw_a,
                       inr_a, hlt_a, cnt_a};
            else
                act = {st_b, irl_b, pcl_b, imp_b, mis_b, asel_b, al_b, sub_b, mw_b,
                       inr_b, hlt_b, 14'd0, cnt_b};
            total++;
            if (act !== it.exp) begin
                bad++;
                $display("FAIL %s: got state=%0d ctrl=%b cnt=%0d, want state=%0d ctrl=%b cnt=%0d",
                         it.tag, act[30:27], act[26:16], act[15:0],
                         it.exp[30:27], it.exp[26:16], it.exp[15:0]);
            end
        end
    end

    initial begin
        clear_a = 1; ir_a = 0; aeq0_a = 0; apos_a = 0; enter_a = 0;
        clear_b = 1; ir_b = 0; aeq0_b = 0; apos_b = 0; enter_b = 0;

        // Reset and LOAD
        cyc(0, 1, 3'b000, 0, 0, 0, 4'd0, 0, "reset0");
        cyc(0, 0, 3'b000, 0, 0, 0, 4'd0, 0, "reset1");
        cyc(0, 0, 3'b000, 0, 0, 0, 4'd1, 0, "fetch_first");
        cyc(0, 0, 3'b000, 0, 0, 0, 4'd2, 0, "decode_load");
        cyc(0, 0, 3'b101, 1, 0, 0, 4'd8, 0, "exec_load");
        // JZ taken, then not taken
        cyc(0, 0, 3'b101, 1, 0, 0, 4'd1, 1, "fetch_after_load");
        cyc(0, 0, 3'b101, 1, 0, 0, 4'd2, 1, "decode_jz");
        cyc(0, 0, 3'b101, 1, 0, 0, 4'd13, 1, "jz_taken");
        cyc(0, 0, 3'b101, 0, 0, 0, 4'd1, 2, "fetch_jz2");
        cyc(0, 0, 3'b101, 0, 0, 0, 4'd2, 2, "decode_jz2");
        cyc(0, 0, 3'b110, 0, 1, 0, 4'd13, 2, "jz_not_taken");
        // JPOS taken
        cyc(0, 0, 3'b110, 0, 1, 0, 4'd1, 3, "fetch_jpos");
        cyc(0, 0, 3'b110, 0, 1, 0, 4'd2, 3, "decode_jpos");
        cyc(0, 0, 3'b001, 0, 1, 0, 4'd14, 3, "jpos_taken");
        // STORE, SUB
        cyc(0, 0, 3'b001, 0, 0, 0, 4'd1, 4, "fetch_store");
        cyc(0, 0, 3'b001, 0, 0, 0, 4'd2, 4, "decode_store");
        cyc(0, 0, 3'b011, 0, 0, 0, 4'd9, 4, "exec_store");
        cyc(0, 0, 3'b011, 0, 0, 0, 4'd1, 5, "fetch_sub");
        cyc(0, 0, 3'b011, 0, 0, 0, 4'd2, 5, "decode_sub");
        cyc(0, 0, 3'b100, 0, 0, 0, 4'd11, 5, "exec_sub");
        // INPUT: five waiting cycles, then Enter
        cyc(0, 0, 3'b100, 0, 0, 0, 4'd1, 6, "fetch_input");
        cyc(0, 0, 3'b100, 0, 0, 0, 4'd2, 6, "decode_input");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 3'b100, 0, 0, 0, 4'd12, 6, "input_wait");
        cyc(0, 0, 3'b111, 0, 0, 1, 4'd12, 6, "input_enter");
        // HALT held 20 cycles, then clear
        cyc(0, 0, 3'b111, 0, 0, 0, 4'd1, 7, "fetch_halt");
        cyc(0, 0, 3'b111, 0, 0, 0, 4'd2, 7, "decode_halt");
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 3'b111, 0, 0, 0, 4'd15, 8, "halt_hold");
        cyc(0, 1, 3'b111, 0, 0, 0, 4'd15, 8, "halt_then_clear");
        cyc(0, 0, 3'b000, 0, 0, 0, 4'd0, 0, "after_halt_clear");
        cyc(0, 0, 3'b000, 0, 0, 0, 4'd1, 0, "fetch_after_clear");

        // DUT B: 2-bit counter saturation, clear mid-SUB
        cyc(1, 0, 3'b010, 0, 0, 0, 4'd0, 0, "b_reset");
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 3'b010, 0, 0, 0, 4'd1, (i < 3) ? i : 3, "b_fetch_add");
            cyc(1, 0, 3'b010, 0, 0, 0, 4'd2, (i < 3) ? i : 3, "b_decode_add");
            cyc(1, 0, 3'b010, 0, 0, 0, 4'd10, (i < 3) ? i : 3, "b_exec_add");
        end
        cyc(1, 0, 3'b011, 0, 0, 0, 4'd1, 3, "b_fetch_saturated");
        cyc(1, 0, 3'b011, 0, 0, 0, 4'd2, 3, "b_decode_sub");
        cyc(1, 1, 3'b011, 0, 0, 0, 4'd11, 3, "b_sub_clear");
        cyc(1, 0, 3'b011, 0, 0, 0, 4'd0, 0, "b_after_clear");
        cyc(1, 0, 3'b011, 0, 0, 0, 4'd1, 0, "b_fetch_after_clear");

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
